// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between the inst master (M0)
// and the data master (M1). One transaction is outstanding at a time. M1
// has priority, but after STARVE_LIMIT consecutive data grants with M0
// waiting, M0 is granted.
//
// Ports:
//   cpu_clk_50M, cpu_rst      clock (rising edge), async active-high reset
//   m0_* / m1_*               master request side (req/wr/size/addr/wdata in,
//                             addr_ok/data_ok out)
//   m_rdata                   shared read data, non-zero only with a data_ok
//   s_*                       slave request side toward the AXI bridge
//   busy                      arbiter is not idle
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_addr_ok,
    output logic              m0_data_ok,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_addr_ok,
    output logic              m1_data_ok,
    output logic [DATA_W-1:0] m_rdata,
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] STARVE_LV = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Granted-master view of the request side
    logic              sel_req;
    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Handshakes before routing to the granted master
    logic addr_ok_c;
    logic data_ok_c;

    // State register
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Select the granted master's request fields
    always_comb begin
        sel_req   = grant_q ? m1_req   : m0_req;
        sel_wr    = grant_q ? m1_wr    : m0_wr;
        sel_size  = grant_q ? m1_size  : m0_size;
        sel_addr  = grant_q ? m1_addr  : m0_addr;
        sel_wdata = grant_q ? m1_wdata : m0_wdata;
    end

    // Next-state, arbitration and bus outputs
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_cnt_d = starve_cnt_q;
        s_req        = 1'b0;
        s_wr         = 1'b0;
        s_size       = 2'b00;
        s_addr       = '0;
        s_wdata      = '0;
        addr_ok_c    = 1'b0;
        data_ok_c    = 1'b0;
        m_rdata      = '0;

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // M1 wins unless M0 has waited through STARVE_LIMIT data grants
                    grant_d = m1_req && !(m0_req && (starve_cnt_q >= STARVE_LV));
                    state_d = ADDR;
                    if (grant_d && m0_req) begin
                        starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX
                                                                 : starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
            end
            ADDR: begin
                s_req     = sel_req;
                s_wr      = sel_wr;
                s_size    = sel_size;
                s_addr    = sel_addr;
                s_wdata   = sel_wdata;
                addr_ok_c = s_addr_ok & sel_req;
                if (!sel_req) begin
                    // Master withdrew before acceptance: abandon without a slave transfer
                    state_d = IDLE;
                end else if (s_addr_ok) begin
                    if (s_data_ok) begin
                        // Slave completed in the accept cycle
                        data_ok_c = 1'b1;
                        m_rdata   = s_rdata;
                        state_d   = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (s_data_ok) begin
                    data_ok_c = 1'b1;
                    m_rdata   = s_rdata;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Route handshakes to the granted master only
    always_comb begin
        m0_addr_ok = addr_ok_c & ~grant_q;
        m0_data_ok = data_ok_c & ~grant_q;
        m1_addr_ok = addr_ok_c &  grant_q;
        m1_data_ok = data_ok_c &  grant_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed vector bench for sram_bus_arbiter. Each
// vector drives one cycle of master/slave inputs on the falling edge and
// checks the combined output bundle shortly after.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int vid    = 0;

    typedef struct {
        logic        m0_req;
        logic        m1_req;
        logic        s_aok;
        logic        s_dok;
        logic [31:0] s_rdata;
        logic [3:0]  e_ok;      // {m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok}
        logic        e_sreq;
        logic        e_busy;
        logic        e_swr;
        logic [1:0]  e_ssize;
        logic [31:0] e_saddr;
        logic [31:0] e_swdata;
        logic [31:0] e_rdata;
    } vec_t;

    sram_bus_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .cpu_clk_50M(clk),
        .cpu_rst    (rst),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_size    (m0_size),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_size    (m1_size),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .m_rdata    (m_rdata),
        .s_req      (s_req),
        .s_wr       (s_wr),
        .s_size     (s_size),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .s_rdata    (s_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic vec_t mk(
        input logic m0r, input logic m1r, input logic aok, input logic dok,
        input logic [31:0] rdata, input logic [3:0] ok, input logic sreq,
        input logic bsy, input logic swr, input logic [1:0] ssize,
        input logic [31:0] saddr, input logic [31:0] swdata, input logic [31:0] mrdata);
        vec_t v;
        v.m0_req   = m0r;
        v.m1_req   = m1r;
        v.s_aok    = aok;
        v.s_dok    = dok;
        v.s_rdata  = rdata;
        v.e_ok     = ok;
        v.e_sreq   = sreq;
        v.e_busy   = bsy;
        v.e_swr    = swr;
        v.e_ssize  = ssize;
        v.e_saddr  = saddr;
        v.e_swdata = swdata;
        v.e_rdata  = mrdata;
        return v;
    endfunction

    function automatic vec_t zero_out(input logic m0r, input logic m1r,
                                      input logic dok, input logic [31:0] rdata);
        return mk(m0r, m1r, 1'b0, dok, rdata, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    endfunction

    task automatic drive(input vec_t v);
        m0_req    = v.m0_req;
        m1_req    = v.m1_req;
        s_addr_ok = v.s_aok;
        s_data_ok = v.s_dok;
        s_rdata   = v.s_rdata;
    endtask

    task automatic check(input vec_t v, input string tag);
        logic [104:0] act;
        logic [104:0] exp_v;
        act   = {m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok, s_req, busy, s_wr,
                 s_size, s_addr, s_wdata, m_rdata};
        exp_v = {v.e_ok, v.e_sreq, v.e_busy, v.e_swr, v.e_ssize, v.e_saddr, v.e_swdata, v.e_rdata};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s vec%0d: got ok=%b sreq=%b busy=%b wr=%b size=%b addr=%h wdata=%h rdata=%h, expected ok=%b sreq=%b busy=%b wr=%b size=%b addr=%h wdata=%h rdata=%h",
                     tag, vid, act[104:101], act[100], act[99], act[98], act[97:96],
                     act[95:64], act[63:32], act[31:0],
                     v.e_ok, v.e_sreq, v.e_busy, v.e_swr, v.e_ssize, v.e_saddr, v.e_swdata, v.e_rdata);
        end
        vid++;
    endtask

    // One cycle: drive on the falling edge, compare just after
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check(v, tag);
    endtask

    vec_t tbl[13];

    initial begin
        rst       = 1'b1;
        m0_req    = 1'b0;  m1_req = 1'b0;
        s_addr_ok = 1'b0;  s_data_ok = 1'b0;  s_rdata = 32'h0;
        m0_wr = 1'b0;  m0_size = 2'b10;  m0_addr = 32'hBFC0_0000;  m0_wdata = 32'h0;
        m1_wr = 1'b1;  m1_size = 2'b10;  m1_addr = 32'h8000_1004;  m1_wdata = 32'hDEAD_BEEF;

        // Reset: all outputs low even with requests and slave oks present
        repeat (2) @(negedge clk);
        m0_req = 1'b1;  m1_req = 1'b1;  s_addr_ok = 1'b1;  s_data_ok = 1'b1;  s_rdata = 32'h1234_5678;
        #1;
        check(zero_out(1'b1, 1'b1, 1'b1, 32'h1234_5678), "reset");
        m0_req = 1'b0;  m1_req = 1'b0;  s_addr_ok = 1'b0;  s_data_ok = 1'b0;  s_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;

        // Inst-only read, data/inst contention, stray data_ok
        tbl[0]  = zero_out(1'b1, 1'b0, 1'b0, 32'h0);
        tbl[1]  = mk(1, 0, 0, 0, 32'h0, 4'b0000, 1, 1, 0, 2'b10, 32'hBFC0_0000, 32'h0, 32'h0);
        tbl[2]  = mk(1, 0, 1, 0, 32'h0, 4'b1000, 1, 1, 0, 2'b10, 32'hBFC0_0000, 32'h0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0, 4'b0000, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0);
        tbl[4]  = mk(0, 0, 0, 1, 32'h3C1D_8000, 4'b0100, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h3C1D_8000);
        tbl[5]  = zero_out(1'b0, 1'b0, 1'b0, 32'h0);
        tbl[6]  = zero_out(1'b1, 1'b1, 1'b0, 32'h0);
        tbl[7]  = mk(1, 1, 1, 0, 32'h0, 4'b0010, 1, 1, 1, 2'b10, 32'h8000_1004, 32'hDEAD_BEEF, 32'h0);
        tbl[8]  = mk(1, 0, 0, 1, 32'h0, 4'b0001, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0);
        tbl[9]  = zero_out(1'b1, 1'b0, 1'b0, 32'h0);
        tbl[10] = mk(1, 0, 1, 0, 32'h0, 4'b1000, 1, 1, 0, 2'b10, 32'hBFC0_0000, 32'h0, 32'h0);
        tbl[11] = mk(0, 0, 0, 1, 32'h1234_5678, 4'b0100, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h1234_5678);
        tbl[12] = zero_out(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 13; i++) step(tbl[i], "table");

        // Starvation: both requests held; expect M1 x4, then M0, then M1
        for (int t = 0; t < 6; t++) begin
            logic g1;
            logic [31:0] rd;
            g1 = (t != 4);
            rd = 32'hA5A5_0000 + 32'(t);
            step(zero_out(1'b1, 1'b1, 1'b0, 32'h0), "starve_idle");
            step(mk(1, 1, 1, 0, 32'h0, g1 ? 4'b0010 : 4'b1000, 1, 1, g1, 2'b10,
                    g1 ? 32'h8000_1004 : 32'hBFC0_0000, g1 ? 32'hDEAD_BEEF : 32'h0, 32'h0),
                 "starve_grant");
            step(mk(1, 1, 0, 1, rd, g1 ? 4'b0001 : 4'b0100, 0, 1, 0, 2'b00,
                    32'h0, 32'h0, rd), "starve_data");
        end

        // M1 lb with addr_ok and data_ok in the same cycle
        m1_wr = 1'b0;  m1_size = 2'b00;  m1_addr = 32'h8000_2003;  m1_wdata = 32'h0;
        step(zero_out(1'b0, 1'b1, 1'b0, 32'h0), "lb_idle");
        step(mk(0, 1, 1, 1, 32'h0000_00AB, 4'b0011, 1, 1, 0, 2'b00, 32'h8000_2003, 32'h0, 32'h0000_00AB),
             "lb_same_cycle");
        step(zero_out(1'b0, 1'b0, 1'b0, 32'h0), "lb_back_idle");

        // Reset asserted in DATA
        step(zero_out(1'b1, 1'b0, 1'b0, 32'h0), "rst_idle");
        step(mk(1, 0, 1, 0, 32'h0, 4'b1000, 1, 1, 0, 2'b10, 32'hBFC0_0000, 32'h0, 32'h0), "rst_addr");
        step(mk(0, 0, 0, 0, 32'h0, 4'b0000, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0), "rst_in_data");
        rst = 1'b1;
        #1;
        check(zero_out(1'b0, 1'b0, 1'b0, 32'h0), "rst_async");
        @(negedge clk);
        rst = 1'b0;
        step(zero_out(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D), "rst_late_dok");
        step(zero_out(1'b1, 1'b0, 1'b0, 32'h0), "rst_fresh_idle");
        step(mk(1, 0, 1, 0, 32'h0, 4'b1000, 1, 1, 0, 2'b10, 32'hBFC0_0000, 32'h0, 32'h0), "rst_fresh_addr");
        step(mk(0, 0, 0, 1, 32'h0BAD_F00D, 4'b0100, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0BAD_F00D),
             "rst_fresh_data");

        // Granted M1 withdraws in ADDR; pending M0 served next
        step(zero_out(1'b1, 1'b1, 1'b0, 32'h0), "wd_idle");
        step(mk(1, 0, 0, 0, 32'h0, 4'b0000, 0, 1, 0, 2'b00, 32'h8000_2003, 32'h0, 32'h0), "wd_drop");
        step(zero_out(1'b1, 1'b0, 1'b0, 32'h0), "wd_back_idle");
        step(mk(1, 0, 1, 0, 32'h0, 4'b1000, 1, 1, 0, 2'b10, 32'hBFC0_0000, 32'h0, 32'h0), "wd_m0_addr");
        step(mk(0, 0, 0, 1, 32'h55AA_55AA, 4'b0100, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h55AA_55AA),
             "wd_m0_data");
        step(zero_out(1'b0, 1'b0, 1'b0, 32'h0), "wd_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like bus (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) between the fetch stage (inst master, M0) and the memory stage (data master, M1) ahead of the AXI bridge.
- Exactly one transaction is outstanding at a time.
- Data master has priority, with a starvation limit that forces periodic inst grants.
- Routes handshakes and read data back to the granted master only.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while inst is pending before inst is forced; range 1..15.

Ports:
- cpu_clk_50M  in  1  clock, rising edge.
- cpu_rst  in  1  asynchronous active-high reset.
- m0_req / m1_req  in  1  master request; held until addr_ok.
- m0_wr / m1_wr  in  1  1 = write.
- m0_size / m1_size  in  2  00 byte, 01 half, 10 word.
- m0_addr / m1_addr  in  ADDR_W  address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_addr_ok / m1_addr_ok  out  1  request accepted.
- m0_data_ok / m1_data_ok  out  1  transaction complete.
- m_rdata  out  DATA_W  read data, shared; valid with the granted data_ok.
- s_req  out  1  slave request.
- s_wr  out  1  slave write.
- s_size  out  2  slave size.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_addr_ok  in  1  slave address accepted.
- s_data_ok  in  1  slave data done.
- s_rdata  in  DATA_W  slave read data.
- busy  out  1  state != IDLE.

Behaviour:
- State machine: IDLE, ADDR, DATA.
- Registered signals: state, grant (0 = M0, 1 = M1), starve_cnt (4 bit).
- Reset (async): state = IDLE, grant = 0, starve_cnt = 0. All outputs 0 during and after reset: s_req, all ok outputs, busy, s_* buses, m_rdata.
- IDLE:
  - No req: stay.
  - Only m1_req: grant = 1.
  - Only m0_req: grant = 0.
  - Both: grant = 1 unless starve_cnt >= STARVE_LIMIT, then grant = 0.
  - On any grant: go to ADDR next cycle. Arbitration adds one cycle of latency: s_req first rises the cycle after the master's req.
- starve_cnt update at each grant:
  - Data grant while m0_req = 1: increment, saturating at 15.
  - Inst grant: clear to 0.
  - Data grant with m0_req = 0: clear to 0.
- ADDR:
  - s_req = granted master's req. s_wr, s_size, s_addr and s_wdata are combinationally muxed from the granted master.
  - granted mN_addr_ok = s_addr_ok & s_req.
  - On s_addr_ok & s_req: go to DATA.
  - Granted master drops req before addr_ok: return to IDLE with no slave transaction; starve_cnt is not undone.
  - s_addr_ok and s_data_ok both high in the same cycle: complete immediately. Forward both oks to the granted master, go to IDLE.
- DATA:
  - s_req = 0; s_* buses = 0.
  - On s_data_ok: granted mN_data_ok = 1 and m_rdata = s_rdata in the same cycle (combinational), then IDLE.
  - New arbitration happens only from IDLE, so back-to-back transactions are spaced by at least one idle cycle.
- Non-granted master: its addr_ok and data_ok stay 0 at all times.
- s_data_ok in IDLE (stray or post-reset): ignored, not forwarded.
- m_rdata = 0 except in the cycle a data_ok is forwarded.
- busy = (state != IDLE).

Test Plan:
- Inst-only read: m0_req, addr 0xBFC00000, size 10. Required: s_req rises 1 cycle later with s_addr = 0xBFC00000. Slave addr_ok at cycle 3 gives m0_addr_ok at cycle 3. Slave data_ok at cycle 5 with rdata 0x3C1D8000 gives m0_data_ok = 1 and m_rdata = 0x3C1D8000 at cycle 5. m1_* oks stay 0 throughout.
- Simultaneous requests, m0 read and m1 sw (addr 0x80001004, wdata 0xDEADBEEF, size 10). Required: data granted first with s_wr = 1 and s_wdata = 0xDEADBEEF. Inst is granted in the next IDLE.
- Starvation: m0_req and m1_req held continuously with STARVE_LIMIT = 4. Required grant sequence: M1, M1, M1, M1, M0, M1, and so on.
- Simultaneous addr_ok and data_ok on an m1 lb: m1_addr_ok and m1_data_ok both 1 in the same cycle; state returns to IDLE next cycle.
- Async reset asserted in DATA: s_req and busy go to 0 immediately. A later s_data_ok produces no mN_data_ok. A fresh m0_req is then served normally.
- Granted m1 withdraws req in ADDR: s_req drops to 0, state returns to IDLE, no addr_ok is issued, and a pending m0 is granted next.
